// File: rtl/ddr_local_rd_engine.sv
// DDR local-queue read executor: splits one descriptor into 4KB/max-burst-safe AXI4 INCR reads, streams beats out on AXIS.
// Accept->arvalid 2 cycles, rvalid->axis_valid 1 cycle; a 2-entry skid buffer throttles rready under stream backpressure.
module ddr_local_rd_engine #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 64,
  parameter int P_MAX_BURST        = 256
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] i_rd_ddr_addr,
  input  logic [15:0]                   i_rd_ddr_len,
  input  logic [7:0]                    i_rd_ddr_strb,
  input  logic                          i_rd_ddr_valid,
  output logic                          o_rd_ddr_ready,
  output logic                          o_rd_ddr_cpl,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] o_m_axi_araddr,
  output logic [7:0]                    o_m_axi_arlen,
  output logic [2:0]                    o_m_axi_arsize,
  output logic [1:0]                    o_m_axi_arburst,
  output logic                          o_m_axi_arvalid,
  input  logic                          i_m_axi_arready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] i_m_axi_rdata,
  input  logic [1:0]                    i_m_axi_rresp,
  input  logic                          i_m_axi_rlast,
  input  logic                          i_m_axi_rvalid,
  output logic                          o_m_axi_rready,
  output logic [C_M_AXI_DATA_WIDTH-1:0] o_m_axis_data,
  output logic [7:0]                    o_m_axis_keep,
  output logic                          o_m_axis_last,
  output logic                          o_m_axis_valid,
  input  logic                          i_m_axis_ready,
  output logic                          o_rd_err
);

  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int DW = C_M_AXI_DATA_WIDTH;

  typedef enum logic [2:0] {S_IDLE, S_CALC, S_AR, S_DATA, S_DRAIN} state_t;
  state_t state_q, state_d;

  logic [AW-1:0] addr_q, araddr_q;
  logic [15:0]   rem_q;
  logic [7:0]    strb_q, arlen_q;
  logic [8:0]    beat_cnt_q;
  logic          cpl_q, err_q;

  logic [1:0]    cnt_q;
  logic [DW-1:0] dat0_q, dat1_q;
  logic [7:0]    keep0_q, keep1_q;
  logic          last0_q, last1_q;

  logic          accept, r_hs, ax_pop, burst_end, in_last;
  logic [7:0]    in_keep;
  logic [9:0]    to4k;
  logic [16:0]   burst;

  assign accept    = (state_q == S_IDLE) && i_rd_ddr_valid;
  assign r_hs      = i_m_axi_rvalid && o_m_axi_rready;
  assign ax_pop    = (cnt_q != 2'd0) && i_m_axis_ready;
  assign burst_end = (beat_cnt_q == 9'd1);
  assign in_last   = (rem_q == 16'd1);
  assign in_keep   = in_last ? strb_q : 8'hFF;

  // Beats left before the 4KB page boundary; range 1..512.
  always_comb begin
    to4k  = 10'((13'd4096 - {1'b0, addr_q[11:0]}) >> 3);
    burst = {1'b0, rem_q};
    if (burst > 17'(P_MAX_BURST)) burst = 17'(P_MAX_BURST);
    if (burst > {7'd0, to4k})     burst = {7'd0, to4k};
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept && i_rd_ddr_len != 16'd0) state_d = S_CALC;
      S_CALC:  state_d = S_AR;
      S_AR:    if (i_m_axi_arready) state_d = S_DATA;
      // Burst boundaries follow our own beat count, not the slave's rlast.
      S_DATA:  if (r_hs && burst_end) state_d = in_last ? S_DRAIN : S_CALC;
      S_DRAIN: if (ax_pop && last0_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      addr_q     <= '0;
      araddr_q   <= '0;
      rem_q      <= '0;
      strb_q     <= '0;
      arlen_q    <= '0;
      beat_cnt_q <= '0;
      cpl_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      cpl_q <= 1'b0;
      if (accept) begin
        addr_q <= i_rd_ddr_addr & ~AW'(7);
        rem_q  <= i_rd_ddr_len;
        strb_q <= i_rd_ddr_strb;
        if (i_rd_ddr_len == 16'd0) cpl_q <= 1'b1;
      end
      if (state_q == S_DRAIN && ax_pop && last0_q) cpl_q <= 1'b1;
      if (state_q == S_CALC) begin
        araddr_q   <= addr_q;
        arlen_q    <= burst[7:0] - 8'd1;
        beat_cnt_q <= burst[8:0];
      end
      if (r_hs) begin
        rem_q      <= rem_q - 16'd1;
        addr_q     <= addr_q + AW'(8);
        beat_cnt_q <= beat_cnt_q - 9'd1;
        if (i_m_axi_rresp != 2'b00 || i_m_axi_rlast != burst_end) err_q <= 1'b1;
      end
    end
  end

  // Slot 0 drives the stream port directly; slot 1 absorbs the beat in flight when the sink stalls.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt_q   <= '0;
      dat0_q  <= '0;
      dat1_q  <= '0;
      keep0_q <= '0;
      keep1_q <= '0;
      last0_q <= 1'b0;
      last1_q <= 1'b0;
    end else begin
      case ({r_hs, ax_pop})
        2'b10: begin
          if (cnt_q == 2'd0) begin
            dat0_q <= i_m_axi_rdata; keep0_q <= in_keep; last0_q <= in_last;
          end else begin
            dat1_q <= i_m_axi_rdata; keep1_q <= in_keep; last1_q <= in_last;
          end
          cnt_q <= cnt_q + 2'd1;
        end
        2'b01: begin
          dat0_q <= dat1_q; keep0_q <= keep1_q; last0_q <= last1_q;
          cnt_q  <= cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) begin
            dat0_q <= i_m_axi_rdata; keep0_q <= in_keep; last0_q <= in_last;
          end else begin
            dat0_q <= dat1_q; keep0_q <= keep1_q; last0_q <= last1_q;
            dat1_q <= i_m_axi_rdata; keep1_q <= in_keep; last1_q <= in_last;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_rd_ddr_ready  = (state_q == S_IDLE);
  assign o_rd_ddr_cpl    = cpl_q;
  assign o_m_axi_araddr  = araddr_q;
  assign o_m_axi_arlen   = arlen_q;
  assign o_m_axi_arsize  = 3'd3;
  assign o_m_axi_arburst = 2'b01;
  assign o_m_axi_arvalid = (state_q == S_AR);
  assign o_m_axi_rready  = (state_q == S_DATA) && (cnt_q != 2'd2);
  assign o_m_axis_data   = dat0_q;
  assign o_m_axis_keep   = keep0_q;
  assign o_m_axis_last   = last0_q;
  assign o_m_axis_valid  = (cnt_q != 2'd0);
  assign o_rd_err        = err_q;

endmodule
